servo_cmd_rx: RTL and testbench
===============================

Name: servo_cmd_rx

Overview:
- Upstream command stage for the remote servo path.
- Receives 8N1 UART frames from the remote controller, validates a 3-byte position packet, and maps the position byte to a duty-cycle value in PWM period ticks.
- Its held duty_cycle output drives the servo/PWM stage's duty_cycle input in place of the local toggle logic.
- Contains one UART receiver and a packet parser FSM.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
DUTY_MIN, 2, duty ticks for position 0x00
DUTY_MAX, 4, duty ticks for position 0xFF; DUTY_MAX >= DUTY_MIN required
DUTY_W, 32, width of duty_cycle
TIMEOUT_CYCLES, 50_000, maximum idle clocks between bytes inside a packet

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rx  in  1  UART line, asynchronous, idles high
duty_cycle  out  DUTY_W  current commanded duty in period ticks, held between updates
duty_valid  out  1  one-cycle pulse when duty_cycle takes a new value
frame_err  out  1  one-cycle pulse on any rejected byte or packet
position  out  8  last accepted raw position byte

Behaviour:
- Reset (synchronous, rst=1 sampled on clk edge): duty_cycle=DUTY_MIN, position=0, duty_valid=0, frame_err=0, parser in SYNC, UART in IDLE. Reset mid-byte or mid-packet discards all partial data.
- rx input: passes through a 2-flop synchronizer, reset value 1. All UART timing refers to the synchronized signal.
- UART FSM states:
  - IDLE: falling edge → START.
  - START: after CLKS_PER_BIT/2 clocks, resample. If still 0 → DATA; otherwise glitch, return to IDLE with no error.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample after CLKS_PER_BIT. If 1 → byte strobe for one cycle. If 0 → framing error: byte dropped, frame_err pulses, parser forced to SYNC, UART goes to IDLE only once the line reads 1.
- Packet format: 0xA5, P, C, where C must equal ~P (bitwise NOT, 8 bits).
- Parser FSM (advances only on byte strobe):
  - SYNC: 0xA5 → POS; any other byte is silently ignored (no frame_err).
  - POS: store P → CHK.
  - CHK: if C==~P, commit and → SYNC. If C!=~P, frame_err pulses and → SYNC. A mismatching 0xA5 in CHK does not re-sync; the next byte is treated as in SYNC.
- Commit mapping: duty_cycle = DUTY_MIN + ((P * (DUTY_MAX-DUTY_MIN+1)) >> 8).
  - Compute at width DUTY_W+9; never exceeds DUTY_MAX.
  - P=0x00 → DUTY_MIN; P=0xFF → DUTY_MAX.
- Commit latency: duty_cycle, position and duty_valid all update on the clock edge after the checksum byte strobe (1 cycle). duty_valid pulses even if the value is unchanged.
- Timeout: in POS or CHK, a counter clears on each byte strobe. When it reaches TIMEOUT_CYCLES with no strobe, frame_err pulses and the parser → SYNC. The counter is inactive in SYNC.
- Simultaneous events:
  - Byte strobe and timeout in the same cycle: the byte wins and the counter clears.
  - Framing error and timeout in the same cycle: a single frame_err pulse.
- frame_err and duty_valid are never asserted in the same cycle.

Decomposition:
- Shared package servo_pkg holds: SYNC_BYTE=8'hA5, parser state encoding (SYNC/POS/CHK), UART state encoding (IDLE/START/DATA/STOP), and DUTY_MIN/DUTY_MAX defaults shared with the servo stage.
- Sub-module uart_rx (params CLK_FREQ, BAUD; ports clk, rst, rx, data[7:0], data_valid, stop_err) contains the synchronizer and UART FSM.
- servo_cmd_rx contains the parser, timeout counter, and mapping.

Test Plan:
Bench uses CLK_FREQ=1_000_000 and BAUD=100_000 (10 clocks/bit), with TIMEOUT_CYCLES=500.
- Apply rst for 3 cycles, rx=1 → duty_cycle=2, position=0, duty_valid=0, frame_err=0.
- Send A5 FF 00 → duty_cycle=4, position=0xFF, duty_valid high exactly 1 cycle, 1 cycle after the 3rd stop-bit sample.
- Send A5 80 7F → duty_cycle=3 (2 + 384>>8). Then send A5 00 FF → duty_cycle=2.
- Send A5 80 00 → frame_err one pulse, no duty_valid, duty_cycle unchanged. Then send 12 34 A5 00 FF → no error for 12/34, duty_cycle=2 with a duty_valid pulse.
- Send A5, then idle 600 clocks → frame_err pulse at 500 clocks after the strobe. Then send A5 FF 00 → accepted, duty_cycle=4.
- Send byte 0xA5 with stop bit 0 → frame_err, parser stays in SYNC. Also assert rst after A5 FF (before the checksum) → duty_cycle=2, and a following lone 00 is not committed.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and state encodings for the remote servo command path.
// The duty defaults match the servo/PWM stage that consumes duty_cycle.
package servo_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         DUTY_MIN_DEF = 2;
  localparam int         DUTY_MAX_DEF = 4;

  typedef enum logic [1:0] {SYNC, POS, CHK} parser_state_t;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer.
// Emits a one-cycle byte strobe, or a one-cycle stop_err on a bad stop bit.
module uart_rx
  import servo_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       stop_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  uart_state_t      state_reg;
  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             wait_high_reg;
  logic             rx_s;

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg      <= 2'b11;
      rx_prev_reg   <= 1'b1;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      wait_high_reg <= 1'b0;
      data          <= '0;
      data_valid    <= 1'b0;
      stop_err      <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= rx_s;
      data_valid  <= 1'b0;
      stop_err    <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (rx_prev_reg && !rx_s) state_reg <= START;
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_s ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          // After a bad stop bit, hold here until the line returns high so a
          // break condition cannot be mistaken for a new start bit.
          if (wait_high_reg) begin
            if (rx_s) begin
              wait_high_reg <= 1'b0;
              state_reg     <= IDLE;
            end
          end else if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (rx_s) begin
              data       <= shift_reg;
              data_valid <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              stop_err      <= 1'b1;
              wait_high_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/servo_cmd_rx.sv
// Remote servo command receiver: parses A5/P/~P packets from the UART and
// maps the position byte onto a duty value between DUTY_MIN and DUTY_MAX.
module servo_cmd_rx
  import servo_pkg::*;
#(
  parameter int CLK_FREQ       = 25_000_000,
  parameter int BAUD           = 115_200,
  parameter int DUTY_MIN       = DUTY_MIN_DEF,
  parameter int DUTY_MAX       = DUTY_MAX_DEF,
  parameter int DUTY_W         = 32,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              frame_err,
  output logic [7:0]        position
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW    = DUTY_W + 9;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              stop_err;
  parser_state_t     state_reg;
  logic [7:0]        pos_cand_reg;
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic [PW-1:0]     scaled;
  logic [DUTY_W-1:0] commit_duty;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (byte_data),
    .data_valid(byte_valid),
    .stop_err  (stop_err)
  );

  // Scale P by the span of duty values; the >>8 keeps the result <= DUTY_MAX.
  always_comb begin
    scaled      = (PW'(pos_cand_reg) * PW'(DUTY_MAX - DUTY_MIN + 1)) >> 8;
    commit_duty = DUTY_W'(scaled) + DUTY_W'(DUTY_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= SYNC;
      pos_cand_reg <= '0;
      tmo_cnt_reg  <= '0;
      duty_cycle   <= DUTY_W'(DUTY_MIN);
      position     <= '0;
      duty_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (stop_err) begin
        frame_err   <= 1'b1;
        state_reg   <= SYNC;
        tmo_cnt_reg <= '0;
      end else if (byte_valid) begin
        tmo_cnt_reg <= '0;
        case (state_reg)
          SYNC: if (byte_data == SYNC_BYTE) state_reg <= POS;
          POS: begin
            pos_cand_reg <= byte_data;
            state_reg    <= CHK;
          end
          CHK: begin
            state_reg <= SYNC;
            if (byte_data == ~pos_cand_reg) begin
              duty_cycle <= commit_duty;
              position   <= pos_cand_reg;
              duty_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_reg <= SYNC;
        endcase
      end else if (state_reg != SYNC) begin
        if (tmo_cnt_reg == TMO_LAST) begin
          frame_err   <= 1'b1;
          state_reg   <= SYNC;
          tmo_cnt_reg <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end else begin
        tmo_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_rx.sv
// Self-checking bench for servo_cmd_rx: packet table plus hand sequences for
// timeout, framing error, noise bytes and mid-packet reset.
module tb_servo_cmd_rx;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [31:0] duty_cycle;
  logic        duty_valid;
  logic        frame_err;
  logic [7:0]  position;

  servo_cmd_rx #(
    .CLK_FREQ      (1_000_000),
    .BAUD          (100_000),
    .DUTY_MIN      (2),
    .DUTY_MAX      (4),
    .DUTY_W        (32),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .duty_cycle(duty_cycle),
    .duty_valid(duty_valid),
    .frame_err (frame_err),
    .position  (position)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int dv_cyc = 0;
  int fe_cyc = 0;
  bit dv_prev = 1'b0;
  logic [39:0] exp_q[$];

  typedef struct {
    logic [7:0]  b0, b1, b2;
    bit          ok;
    logic [31:0] duty;
    logic [7:0]  pos;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard on every duty_valid pulse.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!rst) begin
      if (duty_valid) begin
        dv_cnt++;
        dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_duty_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_duty", duty_cycle, e[39:8]);
          check("sb_position", position, e[7:0]);
          $display("commit duty=%0d position=%02h at cycle %0d", duty_cycle, position, cyc);
        end
      end
      if (frame_err) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (duty_valid && frame_err) check("dv_and_fe_together", 1, 0);
      if (duty_valid && dv_prev) check("dv_pulse_width", 2, 1);
      dv_prev = duty_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, output int t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = cyc;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic run_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input bit ok, input logic [31:0] exp_duty, input logic [7:0] exp_pos);
    int dv0, fe0, t, t2;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    if (ok) exp_q.push_back({exp_duty, exp_pos});
    send_byte(b0, 1'b1, t);
    send_byte(b1, 1'b1, t);
    send_byte(b2, 1'b1, t2);
    repeat (20) @(negedge clk);
    $display("packet %02h %02h %02h: duty=%0d position=%02h", b0, b1, b2, duty_cycle, position);
    check("pkt_duty_valid_count", dv_cnt - dv0, ok ? 1 : 0);
    check("pkt_frame_err_count", fe_cnt - fe0, ok ? 0 : 1);
    check("pkt_duty", duty_cycle, exp_duty);
    check("pkt_position", position, exp_pos);
    if (ok) check_rng("commit_latency", dv_cyc - t2, 97, 101);
  endtask

  initial begin
    int t, dv0, fe0;
    vecs[0] = '{8'hA5, 8'hFF, 8'h00, 1'b1, 32'd4, 8'hFF};
    vecs[1] = '{8'hA5, 8'h80, 8'h7F, 1'b1, 32'd3, 8'h80};
    vecs[2] = '{8'hA5, 8'h00, 8'hFF, 1'b1, 32'd2, 8'h00};
    vecs[3] = '{8'hA5, 8'h80, 8'h00, 1'b0, 32'd2, 8'h00};
    vecs[4] = '{8'hA5, 8'h40, 8'hBF, 1'b1, 32'd2, 8'h40};
    vecs[5] = '{8'hA5, 8'hC0, 8'h3F, 1'b1, 32'd4, 8'hC0};
    vecs[6] = '{8'hA5, 8'hAB, 8'h54, 1'b1, 32'd4, 8'hAB};
    vecs[7] = '{8'hA5, 8'h55, 8'hAA, 1'b1, 32'd2, 8'h55};
    vecs[8] = '{8'hA5, 8'h56, 8'hA9, 1'b1, 32'd3, 8'h56};
    vecs[9] = '{8'hA5, 8'h10, 8'hA5, 1'b0, 32'd3, 8'h56};

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: duty=%0d position=%02h", duty_cycle, position);
    check("reset_duty", duty_cycle, 2);
    check("reset_position", position, 0);
    check("reset_duty_valid", duty_valid, 0);
    check("reset_frame_err", frame_err, 0);

    foreach (vecs[i])
      run_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].ok, vecs[i].duty, vecs[i].pos);

    // A5 in the checksum slot must not re-sync: 10 EF would otherwise commit.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'h10, 1'b1, t);
    send_byte(8'hEF, 1'b1, t);
    repeat (20) @(negedge clk);
    $display("after bad-checksum A5: bytes 10 EF sent");
    check("no_resync_dv", dv_cnt - dv0, 0);
    check("no_resync_fe", fe_cnt - fe0, 0);

    // Noise bytes while hunting for sync are ignored silently.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'h12, 1'b1, t);
    send_byte(8'h34, 1'b1, t);
    repeat (20) @(negedge clk);
    $display("noise bytes 12 34 sent");
    check("noise_fe", fe_cnt - fe0, 0);
    check("noise_dv", dv_cnt - dv0, 0);
    run_pkt(8'hA5, 8'h00, 8'hFF, 1'b1, 32'd2, 8'h00);

    // Inter-byte timeout after a lone sync byte.
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1, t);
    repeat (600) @(negedge clk);
    $display("timeout: frame_err count delta=%0d at offset %0d", fe_cnt - fe0, fe_cyc - t);
    check("timeout_fe_count", fe_cnt - fe0, 1);
    check_rng("timeout_fe_time", fe_cyc - t, 597, 601);
    run_pkt(8'hA5, 8'hFF, 8'h00, 1'b1, 32'd4, 8'hFF);

    // Bad stop bit on a sync byte: error, and the parser is still hunting.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, t);
    repeat (10) @(negedge clk);
    $display("stop-bit error: frame_err count delta=%0d", fe_cnt - fe0);
    check("stop_err_fe", fe_cnt - fe0, 1);
    fe0 = fe_cnt;
    send_byte(8'hFF, 1'b1, t);
    send_byte(8'h00, 1'b1, t);
    repeat (20) @(negedge clk);
    check("stop_err_sync_dv", dv_cnt - dv0, 0);
    check("stop_err_sync_fe", fe_cnt - fe0, 0);
    check("stop_err_duty", duty_cycle, 4);

    // Reset in the middle of a packet discards the partial data.
    send_byte(8'hA5, 1'b1, t);
    send_byte(8'hFF, 1'b1, t);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("mid-packet reset: duty=%0d position=%02h", duty_cycle, position);
    check("midrst_duty", duty_cycle, 2);
    check("midrst_position", position, 0);
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_byte(8'h00, 1'b1, t);
    repeat (20) @(negedge clk);
    check("midrst_lone_dv", dv_cnt - dv0, 0);
    check("midrst_lone_fe", fe_cnt - fe0, 0);
    check("midrst_lone_duty", duty_cycle, 2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
